// File: rtl/buf_rd_ctrl.sv
// Buffer read controller: streams a tile of len words from address 0 through a
// 4-entry output FIFO, issuing reads only when FIFO space is guaranteed.
module buf_rd_ctrl #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [DW-1:0] rd_data,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          process_ena,
    output logic          process_stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    localparam logic [AW:0] ISSUE_ONE = 1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW:0]   r_len;
    logic [AW:0]   r_issued;
    logic          r_inflight;
    logic          r_done;
    logic [2:0]    r_count;
    logic [1:0]    r_wptr;
    logic [1:0]    r_rptr;
    logic [DW-1:0] r_mem [4];

    logic          w_rd_en;
    logic          w_push;
    logic          w_pop;
    logic          w_last;
    logic          w_drained;
    logic          w_load;
    logic          w_zero_done;
    logic [2:0]    w_credit;

    // Credit excludes this cycle's pop so rd_en never depends on out_ready.
    always_comb begin
        w_credit    = r_count + {2'b00, r_inflight};
        w_push      = r_inflight;
        w_pop       = (r_count != 3'd0) && out_ready;
        w_rd_en     = (r_state == S_RUN) && (r_issued < r_len) && (w_credit < 3'd4);
        w_last      = w_rd_en && ((r_issued + ISSUE_ONE) == r_len);
        w_drained   = (r_state == S_DRAIN) && (r_count == 3'd0) && !r_inflight;
        w_load      = (r_state == S_IDLE) && start && (len != '0);
        w_zero_done = (r_state == S_IDLE) && start && (len == '0);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_load)    w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_drained) w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len      <= '0;
            r_issued   <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            r_done     <= w_drained || w_zero_done;
            if (w_load) begin
                r_len    <= len;
                r_issued <= '0;
            end else if (w_rd_en) begin
                r_issued <= r_issued + ISSUE_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
            if (w_push) r_wptr <= r_wptr + 2'd1;
            if (w_pop)  r_rptr <= r_rptr + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= rd_data;
    end

    no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && r_count == 3'd4));

    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign rd_en         = w_rd_en;
    assign rd_addr       = r_issued[AW-1:0];
    assign out_data      = r_mem[r_rptr];
    assign out_valid     = (r_count != 3'd0);
    assign process_ena   = (r_state == S_RUN);
    assign process_stall = (r_state == S_RUN) && !w_rd_en;

endmodule

// File: tb/tb_buf_rd_ctrl.sv
// Bench for buf_rd_ctrl: behavioural buffer, expected-word queue and
// per-scenario tasks covering latency, backpressure, len=0, restart and wrap.
module tb_buf_rd_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] A1 = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          process_ena;
    logic          process_stall;

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] base = '0;
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr = '0;
    int            rem_reads = 0;
    logic          hold_valid = 1'b0;
    logic [DW-1:0] hold_data = '0;

    buf_rd_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .process_ena(process_ena), .process_stall(process_stall)
    );

    always #5 clk = ~clk;

    // Buffer returns base+addr one cycle after the read strobe.
    always @(posedge clk) rd_data <= rd_en ? (base + DW'(rd_addr)) : 32'hDEAD_BEEF;

    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 1'b0;
        end else begin
            if (rd_en) begin
                total++;
                if (rem_reads == 0) begin
                    bad++;
                    $display("FAIL extra_read: got rd_addr=%0d, required no read", rd_addr);
                end else begin
                    if (rd_addr !== exp_addr) begin
                        bad++;
                        $display("FAIL rd_addr: got %0d required %0d", rd_addr, exp_addr);
                    end
                    exp_addr = exp_addr + A1;
                    rem_reads--;
                end
            end
            if (hold_valid && out_valid) begin
                total++;
                if (out_data !== hold_data) begin
                    bad++;
                    $display("FAIL out_stable: got %h required %h", out_data, hold_data);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_word: got %h required none", out_data);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        bad++;
                        $display("FAIL out_data: got %h required %h", out_data, e);
                    end
                end
            end
            hold_valid = out_valid && !out_ready;
            hold_data  = out_data;
        end
    end

    task automatic start_tile(input logic [AW:0] n);
        if (n != '0) begin
            exp_addr  = '0;
            rem_reads = int'(n);
            for (int i = 0; i < int'(n); i++) exp_q.push_back(base + DW'(i));
        end
        start = 1'b1;
        len   = n;
        @(posedge clk); #1;
        start = 1'b0;
        len   = '0;
    endtask

    task automatic run_until_idle(input int budget, input bit rnd, output int dones);
        int cyc;
        dones = 0;
        cyc   = 0;
        while (cyc < budget) begin
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk); #1;
            if (done) dones++;
            cyc++;
            if (!busy) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({busy, done, rd_en, out_valid, process_ena, process_stall} !== 6'b0 || rd_addr !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got flags=%b addr=%0d required 0/0",
                     {busy, done, rd_en, out_valid, process_ena, process_stall}, rd_addr);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int dones;
        base = 32'd100;
        out_ready = 1'b1;
        start_tile(11'd5);
        total++;
        if ({busy, process_ena, rd_en, process_stall, out_valid} !== 5'b11100 || rd_addr !== '0) begin
            bad++;
            $display("FAIL first_cycle: got %b addr=%0d required 11100 addr=0",
                     {busy, process_ena, rd_en, process_stall, out_valid}, rd_addr);
        end
        for (int k = 1; k < 5; k++) begin
            @(posedge clk); #1;
            total++;
            if (rd_en !== 1'b1 || rd_addr !== AW'(k)) begin
                bad++;
                $display("FAIL consecutive_read: got en=%b addr=%0d required 1/%0d", rd_en, rd_addr, k);
            end
            if (k == 1) begin
                total++;
                if (out_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL early_valid: got %b required 0", out_valid);
                end
            end
            if (k == 2) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== 32'd100) begin
                    bad++;
                    $display("FAIL first_word: got v=%b d=%0d required 1/100", out_valid, out_data);
                end
            end
        end
        run_until_idle(50, 1'b0, dones);
        total++;
        if (busy !== 1'b0 || dones != 1) begin
            bad++;
            $display("FAIL basic_done: got busy=%b dones=%0d required 0/1", busy, dones);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL basic_tail: got done=%b left=%0d required 0/0", done, exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        int dones;
        int issues;
        base = 32'd200;
        out_ready = 1'b0;
        start_tile(11'd8);
        issues = rd_en ? 1 : 0;
        for (int c = 1; c < 10; c++) begin
            @(posedge clk); #1;
            if (rd_en) issues++;
        end
        total++;
        if (issues != 4 || rd_en !== 1'b0 || process_stall !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_stall: got issues=%0d en=%b stall=%b busy=%b v=%b required 4/0/1/1/1",
                     issues, rd_en, process_stall, busy, out_valid);
        end
        run_until_idle(60, 1'b0, dones);
        total++;
        if (busy !== 1'b0 || dones != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bp_done: got busy=%b dones=%0d left=%0d required 0/1/0", busy, dones, exp_q.size());
        end
    endtask

    task automatic test_len0;
        out_ready = 1'b1;
        start_tile(11'd0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || rd_en !== 1'b0) begin
            bad++;
            $display("FAIL len0_pulse: got done=%b busy=%b en=%b required 1/0/0", done, busy, rd_en);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL len0_after: got done=%b busy=%b required 0/0", done, busy);
        end
    endtask

    task automatic test_ignore_start;
        int dones;
        base = 32'd300;
        out_ready = 1'b1;
        start_tile(11'd3);
        @(posedge clk); #1;
        start = 1'b1;
        len   = 11'd7;
        @(posedge clk); #1;
        start = 1'b0;
        len   = '0;
        run_until_idle(50, 1'b0, dones);
        total++;
        if (busy !== 1'b0 || dones != 1 || exp_q.size() != 0 || rd_addr !== AW'(3)) begin
            bad++;
            $display("FAIL ignore_start: got busy=%b dones=%0d left=%0d addr=%0d required 0/1/0/3",
                     busy, dones, exp_q.size(), rd_addr);
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        base = 32'd400;
        out_ready = 1'b0;
        start_tile(11'd8);
        repeat (3) begin
            @(posedge clk); #1;
        end
        total++;
        if (out_valid !== 1'b1 || rd_en !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: got v=%b en=%b required 1/1", out_valid, rd_en);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({busy, done, rd_en, out_valid, process_ena, process_stall} !== 6'b0 || rd_addr !== '0) begin
            bad++;
            $display("FAIL mid_reset: got flags=%b addr=%0d required 0/0",
                     {busy, done, rd_en, out_valid, process_ena, process_stall}, rd_addr);
        end
        exp_q.delete();
        rem_reads = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset: got done=%b v=%b required 0/0", done, out_valid);
        end
        base = 32'd500;
        out_ready = 1'b1;
        start_tile(11'd2);
        run_until_idle(40, 1'b0, dones);
        total++;
        if (busy !== 1'b0 || dones != 1 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL restart: got busy=%b dones=%0d left=%0d required 0/1/0", busy, dones, exp_q.size());
        end
    endtask

    task automatic test_random_wrap;
        int dones;
        base = 32'h5000_0000;
        out_ready = 1'b1;
        start_tile(11'd1024);
        run_until_idle(8000, 1'b1, dones);
        total++;
        if (busy !== 1'b0 || dones != 1 || exp_q.size() != 0 || rem_reads != 0 || rd_addr !== '0) begin
            bad++;
            $display("FAIL random_1024: got busy=%b dones=%0d left=%0d reads_left=%0d addr=%0d required 0/1/0/0/0",
                     busy, dones, exp_q.size(), rem_reads, rd_addr);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_len0();
        test_ignore_start();
        test_reset_mid();
        test_random_wrap();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/buf_rd_ctrl.md
BUF_RD_CTRL -- requirements
Module: buf_rd_ctrl

Interface
REQ-001 Parameter AW, default 10: buffer address width.
REQ-002 Parameter DW, default 32: data width.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to read a tile from address 0.
REQ-006 len  input  AW+1  number of words to read, sampled when start=1.
REQ-007 busy  output  1  high whenever state is not IDLE.
REQ-008 done  output  1  one-cycle pulse at tile completion.
REQ-009 rd_en  output  1  buffer read strobe.
REQ-010 rd_addr  output  AW  buffer read address.
REQ-011 rd_data  input  DW  buffer data, valid exactly 1 cycle after rd_en.
REQ-012 out_data  output  DW  stream data (FIFO head).
REQ-013 out_valid  output  1  stream valid.
REQ-014 out_ready  input  1  stream ready from downstream.
REQ-015 process_ena  output  1  enable for the downstream address generator: high in RUN only.
REQ-016 process_stall  output  1  stall for the address generator: high in RUN when rd_en=0, else 0.

Function
REQ-017 The block SHALL have states IDLE, RUN and DRAIN.
REQ-018 IDLE: start=1 with len>0 SHALL load len, clear rd_addr and the issue counter, and move to RUN next cycle.
REQ-019 IDLE: start=1 with len=0 SHALL stay in IDLE and pulse done next cycle, with no reads.
REQ-020 start in RUN or DRAIN SHALL be ignored; len is not re-sampled.
REQ-021 Internal output FIFO: 4 entries, DW wide, registered count 0..4.
REQ-022 In-flight count SHALL equal the registered copy of rd_en (0 or 1).
REQ-023 RUN: rd_en SHALL be 1 iff issued<len and fifo_count+inflight<4, with the pop of the current cycle not counted.
REQ-024 Each rd_en=1 SHALL increment rd_addr and issued by 1 on that edge.
REQ-025 rd_addr SHALL equal issued[AW-1:0]; len=2^AW wraps rd_addr to 0 after the last read.
REQ-026 RUN SHALL go to DRAIN on the edge where the issued count reaches len.
REQ-027 DRAIN SHALL go to IDLE when fifo_count=0, inflight=0 and no push is pending; done SHALL pulse on that transition.
REQ-028 The FIFO SHALL push rd_data on the cycle after rd_en=1.
REQ-029 The FIFO SHALL pop when out_valid and out_ready are both 1.
REQ-030 On a simultaneous push and pop, count SHALL be unchanged and data order preserved.
REQ-031 out_valid SHALL equal fifo_count!=0.
REQ-032 out_data SHALL be the head entry; it SHALL stay stable while out_valid=1 and out_ready=0.
REQ-033 The credit rule SHALL make FIFO overflow impossible; a push into a full FIFO is a design error and is flagged by an assertion.
REQ-034 Latency: start at edge N gives rd_en high in cycle N+1 (addr 0), push at edge N+2, and out_valid from cycle N+2.
REQ-035 With out_ready held at 1, the block SHALL sustain 1 word per cycle.

Reset
REQ-036 While rst=1, the block SHALL be in IDLE with these outputs at 0: rd_addr, issued, fifo_count, inflight, rd_en, done, busy, out_valid, process_ena and process_stall.
REQ-037 Reset mid-tile SHALL discard all FIFO contents and in-flight data; no done pulse is produced.
REQ-038 The first start after reset release SHALL behave as from IDLE.

Verification
REQ-039 len=5, out_ready=1, buffer mem[i]=i+100: rd_addr 0..4 on 5 consecutive cycles; out_data 100..104; one done pulse.
REQ-040 len=8, out_ready=0 until cycle 10, then 1: rd_en stops after 4 issues with process_stall=1; no overflow; 8 words in order.
REQ-041 len=0: no rd_en; done pulses the cycle after start; busy stays 0.
REQ-042 Second start during RUN with len=3: ignored; the first tile completes with its original len.
REQ-043 rst asserted with 2 words in the FIFO and a read in flight: outputs immediately at reset values; a following start with len=2 yields exactly 2 fresh words.
REQ-044 Random out_ready, len=1024, AW=10: 1024 words in order; rd_addr wraps to 0; fifo_count never exceeds 4.
